// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port (instruction fetch = 0, data = 1).
// Alternating priority on ties, registered request capture, optional BUSY timeout with err flag.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds reqN until it sees gntN; from then on the
  // transaction is owned by the arbiter and reqN is ignored. mem_req stays high
  // until the memory answers with mem_ready (sampled on the edge), and doneN
  // pulses for exactly one cycle afterwards (with err on a timeout abort).

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err_q, err_d;

  logic        grant1;
  logic        timeout_hit;

  // Tie goes to whichever requester was not served last.
  assign grant1      = req1 && (!req0 || !last_grant_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    rdata_d      = rdata_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = grant1 ? BUSY1 : BUSY0;
          last_grant_d = grant1;
          cnt_d        = '0;
          mem_addr_d   = grant1 ? addr1  : addr0;
          mem_wdata_d  = grant1 ? wdata1 : wdata0;
          mem_we_d     = grant1 ? we1    : we0;
        end
      end
      BUSY0, BUSY1: begin
        // mem_ready takes precedence over a timeout landing on the same edge.
        if (mem_ready) begin
          state_d = IDLE;
          rdata_d = mem_rdata;
          done0_d = (state_q == BUSY0);
          done1_d = (state_q == BUSY1);
        end else if (timeout_hit) begin
          state_d = IDLE;
          done0_d = (state_q == BUSY0);
          done1_d = (state_q == BUSY1);
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_we_q     <= 1'b0;
      rdata_q      <= 32'h0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      rdata_q      <= rdata_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
    end
  end

  assign gnt0      = (state_q == BUSY0);
  assign gnt1      = (state_q == BUSY1);
  assign mem_req   = (state_q == BUSY0) || (state_q == BUSY1);
  assign sel       = (state_q == BUSY1);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign rdata     = rdata_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
